exec_result_queue: RTL and testbench

Per-functional-unit result queue between one execute-stage FU and the Common Data Bus (CDB) of the 3-way superscalar Tomasulo core. It registers each completed FU result (ROB tag, data, misprediction flag, correct PC) into a small circular FIFO and presents the oldest entry to the CDB with a valid/ready handshake. This decouples FU completion from CDB arbitration and breaks the combinational path out of the execute stage. Three instances are used, one per FU.

---
 rtl/exec_result_queue.sv | 118 +++++++++++
 tb/tb_exec_result_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_result_queue.sv
// Per-FU result queue: registers completed FU results into a circular FIFO and
// presents the oldest entry to the CDB with a valid/ready handshake.
module exec_result_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_mispred,
  input  logic [DATA_WIDTH-1:0]        in_correct_pc,
  output logic                         cdb_valid,
  input  logic                         cdb_ready,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         cdb_mispred,
  output logic [DATA_WIDTH-1:0]        cdb_correct_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  mis_q  [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake status is derived from registered occupancy only.
  always_comb begin
    in_ready  = (count_q < CntW'(DEPTH));
    cdb_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = cdb_valid && cdb_ready && !flush;
  end

  // Next-state for pointers and occupancy; flush discards any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; the redirect PC is word-aligned on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        mis_q[i]  <= 1'b0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      tag_q[wr_ptr_q]  <= in_tag;
      data_q[wr_ptr_q] <= in_data;
      mis_q[wr_ptr_q]  <= in_mispred;
      pc_q[wr_ptr_q]   <= {in_correct_pc[DATA_WIDTH-1:2], 2'b00};
    end
  end

  // Head payload, forced to zero while empty.
  always_comb begin
    cdb_tag        = '0;
    cdb_data       = '0;
    cdb_mispred    = 1'b0;
    cdb_correct_pc = '0;
    if (cdb_valid) begin
      cdb_tag        = tag_q[rd_ptr_q];
      cdb_data       = data_q[rd_ptr_q];
      cdb_mispred    = mis_q[rd_ptr_q];
      cdb_correct_pc = pc_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_exec_result_queue.sv
// Directed bench for exec_result_queue with a queue-based reference model.
module tb_exec_result_queue;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_mispred;
  logic [TW-1:0] in_tag, cdb_tag;
  logic [DW-1:0] in_data, in_correct_pc, cdb_data, cdb_correct_pc;
  logic          cdb_valid, cdb_ready, cdb_mispred;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          mis;
    logic [DW-1:0] pc;
  } entry_t;

  entry_t model_q[$];

  exec_result_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_tag         (in_tag),
    .in_data        (in_data),
    .in_mispred     (in_mispred),
    .in_correct_pc  (in_correct_pc),
    .cdb_valid      (cdb_valid),
    .cdb_ready      (cdb_ready),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .cdb_mispred    (cdb_mispred),
    .cdb_correct_pc (cdb_correct_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most DEPTH entries, cleared by flush or reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else begin
      bit do_push, do_pop;
      entry_t e;
      do_push = in_valid && (model_q.size() < DEPTH) && !flush;
      do_pop  = (model_q.size() != 0) && cdb_ready && !flush;
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.tag  = in_tag;
          e.data = in_data;
          e.mis  = in_mispred;
          e.pc   = {in_correct_pc[DW-1:2], 2'b00};
          model_q.push_back(e);
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_count", 64'(count), 64'(model_q.size()));
      chk("m_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      chk("m_cdb_valid", 64'(cdb_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        chk("m_cdb_tag", 64'(cdb_tag), 64'(model_q[0].tag));
        chk("m_cdb_data", 64'(cdb_data), 64'(model_q[0].data));
        chk("m_cdb_mispred", 64'(cdb_mispred), 64'(model_q[0].mis));
        chk("m_cdb_pc", 64'(cdb_correct_pc), 64'(model_q[0].pc));
      end else begin
        chk("m_empty_payload", {cdb_tag, cdb_mispred, cdb_data}, 64'd0);
        chk("m_empty_pc", 64'(cdb_correct_pc), 64'd0);
      end
    end
  end

  // Advance to just after the next falling edge; inputs change only here.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                       input logic [DW-1:0] pc);
    in_valid      = v;
    in_tag        = t;
    in_data       = d;
    in_mispred    = t[0];
    in_correct_pc = pc;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({pfx, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
    chk({pfx, "_count"}, 64'(count), 64'd0);
    chk({pfx, "_payload"}, {cdb_tag, cdb_mispred, cdb_data}, 64'd0);
    chk({pfx, "_pc"}, 64'(cdb_correct_pc), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // Single push: PC low bits cleared, visible after the capturing edge.
    drive(1'b1, 5'd3, 32'h0000_00AA, 32'h0000_1003);
    cyc();
    drive(1'b0, '0, '0, '0);
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag", 64'(cdb_tag), 64'd3);
    chk("t1_data", 64'(cdb_data), 64'h0000_00AA);
    chk("t1_pc", 64'(cdb_correct_pc), 64'h0000_1000);
    chk("t1_mispred", 64'(cdb_mispred), 64'd1);
    chk("t1_count", 64'(count), 64'd1);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;
    chk("t1_drained", 64'(count), 64'd0);

    // Fill with backpressure, then a refused fifth push held for 10 cycles.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, TW'(i), 32'h100 + 32'(i), 32'h2000 + 32'(4 * i) + 32'd2);
      cyc();
    end
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd5, 32'h105, 32'h2014);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_head_hold", 64'(cdb_tag), 64'd1);
      chk("t2_count_hold", 64'(count), 64'd4);
    end
    // Full queue popping still refuses the concurrent push.
    cdb_ready = 1'b1;
    cyc();
    drive(1'b0, '0, '0, '0);
    chk("t2_pop_from_full", 64'(count), 64'd3);
    chk("t2_ready_after_pop", 64'(in_ready), 64'd1);
    chk("t2_next_head", 64'(cdb_tag), 64'd2);
    repeat (3) cyc();
    chk("t2_empty", 64'(count), 64'd0);

    // Streaming across pointer wrap: one in, one out per cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, TW'(i), 32'h11 * 32'(i), 32'h4000 + 32'(4 * i) + 32'd1);
      cyc();
      chk("t3_stream_tag", 64'(cdb_tag), 64'(i));
      chk("t3_stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, '0, '0);
    cyc();
    chk("t3_stream_end", 64'(count), 64'd0);

    // Simultaneous push and pop at count 2.
    cdb_ready = 1'b0;
    drive(1'b1, 5'd7, 32'h77, 32'h7000);
    cyc();
    drive(1'b1, 5'd8, 32'h88, 32'h8000);
    cyc();
    chk("t4_count2", 64'(count), 64'd2);
    chk("t4_head7", 64'(cdb_tag), 64'd7);
    drive(1'b1, 5'd9, 32'h99, 32'h9000);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;
    drive(1'b1, 5'd10, 32'hAA0, 32'hA000);
    chk("t4_count_same", 64'(count), 64'd2);
    chk("t4_head8", 64'(cdb_tag), 64'd8);

    // Flush with concurrent push and grant: everything discarded.
    cyc();
    chk("t5_count3", 64'(count), 64'd3);
    drive(1'b1, 5'd12, 32'hC, 32'hC000);
    flush = 1'b1;
    cdb_ready = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk_reset_outputs("t5_flush");
    repeat (3) cyc();
    chk("t5_no_tag12", 64'(cdb_valid), 64'd0);
    cdb_ready = 1'b0;

    // Asynchronous reset between edges with two entries queued.
    drive(1'b1, 5'd1, 32'h1, 32'h10);
    cyc();
    drive(1'b1, 5'd2, 32'h2, 32'h20);
    cyc();
    drive(1'b0, '0, '0, '0);
    chk("t6_count2", 64'(count), 64'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    cyc();
    rst = 1'b0;
    drive(1'b1, 5'd21, 32'h5555_0001, 32'hFFFF_FFFF);
    cyc();
    drive(1'b0, '0, '0, '0);
    chk("t6_post_tag", 64'(cdb_tag), 64'd21);
    chk("t6_post_pc", 64'(cdb_correct_pc), 64'hFFFF_FFFC);
    cdb_ready = 1'b1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
